// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clock-divider controller: FSM states, pending-action kinds
// and the default largest divider exponent.
package clk_div_ctrl_pkg;

  localparam int DIV_MAX_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef enum logic [1:0] {NONE, REQ, STOP} pend_e;

endpackage

// File: rtl/div_period_cnt.sv
// Period counter for the divider: counts busy cycles and flags the last cycle
// of each 2^div period, clearing itself on that cycle.
module div_period_cnt
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_MAX = DIV_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] div,
  output logic       tick
);

  logic [DIV_MAX-1:0] cnt_q, cnt_d, last;

  always_comb begin
    last = DIV_MAX'((32'd1 << div) - 32'd1);
    tick = en && (cnt_q == last);
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: accepts divider requests, emits tick enables at
// 2^div spacing, runs finite or continuous bursts and drains at period boundaries.
module clk_div_ctrl
  import clk_div_ctrl_pkg::*;
#(
  parameter int DIV_MAX = DIV_MAX_DEF,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_div,
  input  logic [LEN_W-1:0] req_len,
  output logic             req_ready,
  input  logic             stop,
  output logic             tick,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [2:0]       div_cur
);

  state_e           state_q, state_d;
  pend_e            pend_q, pend_d;
  logic [2:0]       div_q, div_d, pdiv_q, pdiv_d;
  logic [LEN_W-1:0] rem_q, rem_d, plen_q, plen_d;
  logic             err_q, clr, accept, bad, take;

  div_period_cnt #(.DIV_MAX(DIV_MAX)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (busy),
    .clr  (clr),
    .div  (div_q),
    .tick (tick)
  );

  always_comb begin
    busy      = (state_q != IDLE);
    req_ready = (state_q != DRAIN) && !stop;
    accept    = req_valid && req_ready;
    bad       = (req_div > 3'(DIV_MAX));
    take      = accept && !bad;
    done      = tick && (rem_q == LEN_W'(1));
    err       = err_q;
    div_cur   = div_q;

    state_d = state_q;
    pend_d  = pend_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    rem_d   = rem_q;
    plen_d  = plen_q;
    clr     = 1'b0;

    if (tick && (rem_q != '0)) rem_d = rem_q - 1'b1;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = RUN;
          div_d   = req_div;
          rem_d   = req_len;
          clr     = 1'b1;
        end
      end
      RUN: begin
        // A request or stop arriving on a tick already sits on a period boundary.
        if (tick) begin
          if (stop) begin
            state_d = IDLE;
          end else if (take) begin
            div_d = req_div;
            rem_d = req_len;
            clr   = 1'b1;
          end else if (done) begin
            state_d = IDLE;
          end
        end else if (stop) begin
          pend_d  = STOP;
          state_d = DRAIN;
        end else if (take) begin
          pend_d  = REQ;
          pdiv_d  = req_div;
          plen_d  = req_len;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tick) begin
          pend_d = NONE;
          if (pend_q == REQ) begin
            state_d = RUN;
            div_d   = pdiv_q;
            rem_d   = plen_q;
            clr     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= NONE;
      div_q   <= '0;
      pdiv_q  <= '0;
      rem_q   <= '0;
      plen_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      rem_q   <= rem_d;
      plen_q  <= plen_d;
      err_q   <= accept && bad;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: per-cycle vector table plus a reset-abort sequence.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_div = '0;
  logic [7:0] req_len = '0;
  logic       stop = 1'b0;
  logic       req_ready, tick, done, err, busy;
  logic [2:0] div_cur;

  int checks = 0;
  int failures = 0;

  clk_div_ctrl #(.DIV_MAX(4), .LEN_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_div  (req_div),
    .req_len  (req_len),
    .req_ready(req_ready),
    .stop     (stop),
    .tick     (tick),
    .done     (done),
    .err      (err),
    .busy     (busy),
    .div_cur  (div_cur)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rst, vld;
    bit [2:0] div;
    bit [7:0] len;
    bit       stp, chk;
    bit       tk, dn, er, bs, rd;
    bit [2:0] dc;
  } vec_t;

  vec_t vec[$];

  function automatic void add(bit rst, bit vld, bit [2:0] d, bit [7:0] l, bit stp, bit chk,
                              bit tk, bit dn, bit er, bit bs, bit rd, bit [2:0] dc);
    vec_t r;
    r.rst = rst; r.vld = vld; r.div = d; r.len = l; r.stp = stp; r.chk = chk;
    r.tk = tk; r.dn = dn; r.er = er; r.bs = bs; r.rd = rd; r.dc = dc;
    vec.push_back(r);
  endfunction

  // Repeated cycles with no inputs asserted.
  function automatic void rep(int n, bit tk, bit dn, bit bs, bit rd, bit [2:0] dc);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 1, tk, dn, 0, bs, rd, dc);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    // Reset then div=2 len=3: ticks 4/8/12 cycles after acceptance, done on the third.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 2, 3, 0, 1, 0, 0, 0, 0, 1, 0);
    rep(3, 0, 0, 1, 1, 2);
    rep(1, 1, 0, 1, 1, 2);
    rep(3, 0, 0, 1, 1, 2);
    rep(1, 1, 0, 1, 1, 2);
    rep(3, 0, 0, 1, 1, 2);
    rep(1, 1, 1, 1, 1, 2);
    // div=0 continuous, stop on a tick cycle returns to IDLE next cycle.
    add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
    rep(2, 1, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0);
    // Invalid exponent: err one cycle later, nothing else moves.
    add(0, 1, 6, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0);
    // div=3, stop and request together mid-period: stop wins, drain to IDLE.
    add(0, 1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    rep(2, 0, 0, 1, 1, 3);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 3);
    rep(4, 0, 0, 1, 0, 3);
    rep(1, 1, 0, 1, 0, 3);
    // div=4 continuous, request div=1 at cnt=5: tick 10 cycles later, then every 2.
    add(0, 1, 4, 0, 0, 1, 0, 0, 0, 0, 1, 3);
    rep(5, 0, 0, 1, 1, 4);
    add(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 1, 4);
    rep(9, 0, 0, 1, 0, 4);
    rep(1, 1, 0, 1, 0, 4);
    rep(1, 0, 0, 1, 1, 1);
    rep(1, 1, 0, 1, 1, 1);
    rep(1, 0, 0, 1, 1, 1);
    rep(1, 1, 0, 1, 1, 1);
    // Stop mid-period, DRAIN ends on the next tick.
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1);
    rep(1, 1, 0, 1, 0, 1);
    // Final burst tick lands in DRAIN: done pulses and the pending request loads.
    add(0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 1, 1);
    rep(1, 0, 0, 1, 1, 1);
    rep(1, 1, 0, 1, 1, 1);
    add(0, 1, 2, 0, 0, 1, 0, 0, 0, 1, 1, 1);
    rep(1, 1, 1, 1, 0, 1);
    rep(1, 0, 0, 1, 1, 2);

    foreach (vec[i]) begin
      @(negedge clk);
      reset = vec[i].rst; req_valid = vec[i].vld; req_div = vec[i].div;
      req_len = vec[i].len; stop = vec[i].stp;
      #1;
      if (vec[i].chk)
        chk($sformatf("row%0d {tick,done,err,busy,ready,div}", i),
            {26'd0, tick, done, err, busy, req_ready, div_cur},
            {26'd0, vec[i].tk, vec[i].dn, vec[i].er, vec[i].bs, vec[i].rd, vec[i].dc});
    end

    // Reset after the second tick of a div=3 len=5 burst.
    @(negedge clk); reset = 1'b1; req_valid = 1'b0; stop = 1'b0;
    @(negedge clk); reset = 1'b0; req_valid = 1'b1; req_div = 3'd3; req_len = 8'd5;
    @(negedge clk); req_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      #1;
      if (tick) n++;
      if (n < 2) @(negedge clk);
    end
    chk("abort_two_ticks_seen", n, 2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("abort_outputs_after_reset", {26'd0, tick, done, err, busy, req_ready, div_cur},
        {26'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (tick || busy) n++;
    end
    chk("abort_no_further_ticks", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter DIV_MAX, default 4: largest divider exponent; divisor = 2^div, covering /1, /2, /4, /8 and /16.
REQ-002 Parameter LEN_W, default 8: width of the burst-length field.
REQ-003 clk  in  1: the single clock; all logic is rising-edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 req_valid  in  1: divider request present.
REQ-006 req_div  in  3: requested exponent; valid codes are 0..DIV_MAX.
REQ-007 req_len  in  LEN_W: tick count for the burst; 0 means continuous.
REQ-008 req_ready  out  1: request accepted when req_valid and req_ready are both high on a clock edge.
REQ-009 stop  in  1: halt at the next period boundary.
REQ-010 tick  out  1: one-cycle enable pulse on the last cycle of each divided period.
REQ-011 done  out  1: one-cycle pulse coinciding with the final tick of a finite burst.
REQ-012 err  out  1: one-cycle pulse, registered, on the cycle after an invalid request is accepted.
REQ-013 busy  out  1: high in RUN and DRAIN.
REQ-014 div_cur  out  3: exponent currently applied; holds its last value in IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-016 The period counter cnt SHALL be DIV_MAX bits wide, increment every cycle in RUN and DRAIN, and clear to 0 on a tick.
REQ-017 tick SHALL equal (busy and cnt == 2^div_cur - 1), decoded from registers with no extra latency; with div_cur = 0, tick is high on every busy cycle.
REQ-018 req_ready SHALL equal (state != DRAIN and not stop).
REQ-019 IDLE, on a valid accepted request: the FSM SHALL enter RUN next cycle with cnt = 0, div_cur = req_div and remaining = req_len. The first tick falls 2^div cycles after acceptance.
REQ-020 Any state, on an accepted request with req_div > DIV_MAX: the block SHALL pulse err, leave state unchanged and leave div_cur unchanged.
REQ-021 RUN, on a valid accepted request: the block SHALL store it as pending and enter DRAIN; the current period completes unchanged.
REQ-022 RUN, with stop high: the block SHALL set pending = STOP and enter DRAIN; stop is ignored in IDLE and DRAIN.
REQ-023 DRAIN, on a tick with pending = STOP: the FSM SHALL return to IDLE.
REQ-024 DRAIN, on a tick with a pending request: the block SHALL load that request and enter RUN with cnt = 0.
REQ-025 Finite burst, remaining != 0: remaining SHALL decrement on each tick. A tick with remaining == 1 asserts done; in RUN it also returns the FSM to IDLE.
REQ-026 If the final burst tick occurs in DRAIN: done SHALL still pulse, and the pending action (request or stop) takes effect.
REQ-027 Continuous mode (remaining == 0): the block SHALL never assert done.
REQ-028 stop and req_valid in the same cycle: stop SHALL win and the request SHALL NOT be accepted.
REQ-029 cnt SHALL NOT wrap past 2^DIV_MAX - 1, because a tick always clears it first.

Reset
REQ-030 On reset: state = IDLE; cnt, remaining, pending and div_cur SHALL be 0; tick, done, err and busy SHALL be 0; req_ready SHALL be 1 on the first cycle after reset.
REQ-031 Reset SHALL override every input, abort any burst or DRAIN mid-operation, and discard the pending request without producing a tick.

Structure
REQ-032 Package clk_div_ctrl_pkg SHALL hold the state enum (IDLE/RUN/DRAIN), the pending-kind enum (NONE/REQ/STOP) and the DIV_MAX default.
REQ-033 Sub-module div_period_cnt SHALL hold cnt and the tick decode; inputs are clk, reset, en, clr and div; output is tick.
REQ-034 The FSM, pending register and burst counter SHALL reside in clk_div_ctrl.

Verification
REQ-035 Reset, then request div=2, len=3: ticks 4, 8 and 12 cycles after acceptance; done with the third tick; busy low on the next cycle.
REQ-036 Request div=0, len=0: tick high on every cycle; done never asserted; stop returns the FSM to IDLE on the next cycle.
REQ-037 Running div=4 continuous, request div=1 at cnt=5: a tick 10 cycles later, then ticks every 2 cycles; div_cur changes to 1 right after that tick.
REQ-038 Running div=3, stop and req_valid high in the same cycle: req_ready is low, the request is not taken, the FSM returns to IDLE after the current 8-cycle period, and div_cur stays 3.
REQ-039 Request req_div=6: err pulses one cycle later; state and div_cur are unchanged; no tick.
REQ-040 Running div=3, len=5: reset asserted after the second tick gives zero outputs the next cycle and no further ticks.
